// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display path: conversion FSM
// states, digit index type and active-low 7-segment encodings.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        DIV_SEC = 3'd2,
        DIV_MIN = 3'd3,
        COMMIT  = 3'd4
    } disp_state_t;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9.
    localparam logic [6:0] SEG7_LUT [10] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000,
        7'b0000000,
        7'b0010000
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes
// produce a dark digit.
module bcd_to_seg7
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG7_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG7_LUT[bcd];
        end
    end

endmodule

// File: rtl/time_display.sv
// MM.SS display driver: snapshots the time bus once per scan frame, converts it
// to BCD by repeated subtraction, and multiplexes four common-anode digits.
module time_display
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter bit BLANK_LEAD = 1'b1
) (
    input  logic       clk_high_speed,
    input  logic       rst_n,
    input  logic [5:0] time_min,
    input  logic [5:0] time_sec,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pcnt;
    logic          tick;
    digit_idx_t    idx;

    disp_state_t state;
    disp_state_t state_next;

    logic [5:0] rem_sec;
    logic [5:0] rem_min;
    logic [2:0] tens_sec;
    logic [2:0] tens_min;

    logic [3:0] buf_sec_ones;
    logic [2:0] buf_sec_tens;
    logic [3:0] buf_min_ones;
    logic [2:0] buf_min_tens;

    logic [3:0] sel_digit;
    logic       sel_blank;
    logic [6:0] sel_seg;

    assign tick = (pcnt == PCNT_LAST);

    always_ff @(posedge clk_high_speed or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
            if (tick) begin
                idx <= idx + 2'd1;
            end
        end
    end

    always_comb begin
        sel_digit = buf_sec_ones;
        case (idx)
            2'd0:    sel_digit = buf_sec_ones;
            2'd1:    sel_digit = {1'b0, buf_sec_tens};
            2'd2:    sel_digit = buf_min_ones;
            default: sel_digit = {1'b0, buf_min_tens};
        endcase
    end

    assign sel_blank = BLANK_LEAD && (idx == 2'd3) && (buf_min_tens == 3'd0);

    bcd_to_seg7 u_bcd_to_seg7 (
        .bcd (sel_digit),
        .seg (sel_seg)
    );

    // Outputs change only on tick, so each digit is held steady for a full slot.
    always_ff @(posedge clk_high_speed or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'hF;
            seg <= SEG7_BLANK;
            dp  <= 1'b1;
        end else if (tick) begin
            if (sel_blank) begin
                an  <= 4'hF;
                seg <= SEG7_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= ~(4'b0001 << idx);
                seg <= sel_seg;
                dp  <= (idx != 2'd2);
            end
        end
    end

    always_ff @(posedge clk_high_speed or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick && idx == 2'd3) state_next = LOAD;
            LOAD:    state_next = DIV_SEC;
            DIV_SEC: if (rem_sec < 6'd10) state_next = DIV_MIN;
            DIV_MIN: if (rem_min < 6'd10) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Snapshot happens at the end of the last slot; the buffer is written in
    // one cycle so a frame never mixes digits from two different snapshots.
    always_ff @(posedge clk_high_speed or negedge rst_n) begin
        if (!rst_n) begin
            rem_sec      <= '0;
            rem_min      <= '0;
            tens_sec     <= '0;
            tens_min     <= '0;
            buf_sec_ones <= '0;
            buf_sec_tens <= '0;
            buf_min_ones <= '0;
            buf_min_tens <= '0;
        end else begin
            case (state)
                LOAD: begin
                    rem_sec  <= time_sec;
                    rem_min  <= time_min;
                    tens_sec <= '0;
                    tens_min <= '0;
                end
                DIV_SEC: begin
                    if (rem_sec >= 6'd10) begin
                        rem_sec  <= rem_sec - 6'd10;
                        tens_sec <= tens_sec + 3'd1;
                    end
                end
                DIV_MIN: begin
                    if (rem_min >= 6'd10) begin
                        rem_min  <= rem_min - 6'd10;
                        tens_min <= tens_min + 3'd1;
                    end
                end
                COMMIT: begin
                    buf_sec_ones <= rem_sec[3:0];
                    buf_sec_tens <= tens_sec;
                    buf_min_ones <= rem_min[3:0];
                    buf_min_tens <= tens_min;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display with a 20-cycle slot: reset, digit encoding,
// leading-zero blanking, frame coherence, conversion latency and mid-conversion reset.
module tb_time_display;
    import stopwatch_pkg::*;

    localparam int SLOT = 20;

    logic       clk_high_speed;
    logic       rst_n;
    logic [5:0] time_min;
    logic [5:0] time_sec;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks;
    int failures;

    logic [3:0] fr_an  [4];
    logic [6:0] fr_seg [4];
    logic       fr_dp  [4];

    time_display #(
        .SCAN_DIV   (SLOT),
        .BLANK_LEAD (1'b1)
    ) dut (
        .clk_high_speed (clk_high_speed),
        .rst_n          (rst_n),
        .time_min       (time_min),
        .time_sec       (time_sec),
        .an             (an),
        .seg            (seg),
        .dp             (dp)
    );

    // clock / reset
    initial clk_high_speed = 1'b0;
    always #5 clk_high_speed = ~clk_high_speed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the start of a fresh frame (sec-ones slot just loaded).
    task automatic sync_frame(input string tag);
        int n;
        n = 0;
        while (an == 4'b1110 && n < 200) begin
            @(negedge clk_high_speed);
            n++;
        end
        while (an != 4'b1110 && n < 400) begin
            @(negedge clk_high_speed);
            n++;
        end
        check({tag, "_sync"}, 32'(an), 32'(4'b1110));
    endtask

    task automatic capture_frame(input string tag);
        sync_frame(tag);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (SLOT) @(negedge clk_high_speed);
            fr_an[i]  = an;
            fr_seg[i] = seg;
            fr_dp[i]  = dp;
        end
    endtask

    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input bit blank3);
        logic [11:0] exp_slot [4];
        exp_slot[0] = {4'b1110, s0, 1'b1};
        exp_slot[1] = {4'b1101, s1, 1'b1};
        exp_slot[2] = {4'b1011, s2, 1'b0};
        exp_slot[3] = blank3 ? {4'b1111, 7'h7F, 1'b1} : {4'b0111, s3, 1'b1};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_slot%0d", tag, i), 32'({fr_an[i], fr_seg[i], fr_dp[i]}),
                  32'(exp_slot[i]));
        end
    endtask

    task automatic set_time(input logic [5:0] m, input logic [5:0] s);
        @(negedge clk_high_speed);
        time_min = m;
        time_sec = s;
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        time_min = 6'd0;
        time_sec = 6'd0;
        #1 rst_n = 1'b0;

        // 1. reset and first slot after release
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_high_speed);
            if (i == 0 || i == 25 || i == 49)
                check($sformatf("rst_hold_%0d", i), 32'({an, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
        end
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        for (int i = 0; i < SLOT - 1; i++) begin
            @(posedge clk_high_speed);
            @(negedge clk_high_speed);
            check($sformatf("post_rst_blank_%0d", i), 32'({an, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
        end
        @(posedge clk_high_speed);
        @(negedge clk_high_speed);
        check("first_slot", 32'({an, seg, dp}), 32'({4'b1110, 7'b1000000, 1'b1}));

        // 2. 12:34
        set_time(6'd12, 6'd34);
        repeat (8 * SLOT) @(negedge clk_high_speed);
        capture_frame("t1234");
        check_frame("t1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 1'b0);

        // 3. 05:09 with leading blank
        set_time(6'd5, 6'd9);
        repeat (8 * SLOT) @(negedge clk_high_speed);
        capture_frame("t0509");
        check_frame("t0509", 7'b0010000, 7'b1000000, 7'b0010010, 7'h7F, 1'b1);

        // 4. change mid-frame must not tear the frame on screen
        set_time(6'd12, 6'd34);
        repeat (8 * SLOT) @(negedge clk_high_speed);
        sync_frame("tear");
        repeat (SLOT) @(negedge clk_high_speed);
        check("tear_slot1", 32'({an, seg}), 32'({4'b1101, 7'b0110000}));
        time_sec = 6'd35;
        repeat (SLOT) @(negedge clk_high_speed);
        check("tear_slot2", 32'({an, seg, dp}), 32'({4'b1011, 7'b0100100, 1'b0}));
        repeat (SLOT) @(negedge clk_high_speed);
        check("tear_slot3", 32'({an, seg}), 32'({4'b0111, 7'b1111001}));
        capture_frame("tear_next");
        check_frame("tear_next", 7'b0010010, 7'b0110000, 7'b0100100, 7'b1111001, 1'b0);

        // 5. 63:63 and worst-case conversion latency
        set_time(6'd63, 6'd63);
        n = 0;
        while (dut.state != LOAD && n < 200) begin
            @(negedge clk_high_speed);
            n++;
        end
        check("wait_load", 32'(dut.state), 32'(LOAD));
        n = 0;
        while (dut.state != IDLE && n < 40) begin
            @(negedge clk_high_speed);
            n++;
        end
        check("conv_latency", 32'(n), 32'd16);
        capture_frame("t6363");
        check_frame("t6363", 7'b0110000, 7'b0000010, 7'b0110000, 7'b0000010, 1'b0);

        // 6. reset during DIV_SEC
        set_time(6'd59, 6'd59);
        n = 0;
        while (dut.state != DIV_SEC && n < 200) begin
            @(negedge clk_high_speed);
            n++;
        end
        check("wait_div_sec", 32'(dut.state), 32'(DIV_SEC));
        rst_n = 1'b0;
        #1;
        check("midrst_out", 32'({an, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
        check("midrst_state", 32'(dut.state), 32'(IDLE));
        repeat (3) @(negedge clk_high_speed);
        rst_n = 1'b1;
        capture_frame("midrst_f0");
        check_frame("midrst_f0", 7'b1000000, 7'b1000000, 7'b1000000, 7'h7F, 1'b1);
        capture_frame("midrst_f1");
        check_frame("midrst_f1", 7'b0010000, 7'b0010010, 7'b0010000, 7'b0010010, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
